// File: rtl/uart_pkg.sv
// Shared types and limits for the UART transmit path: FSM state encoding,
// legal parameter ranges and the frame parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_START  = 3'b001,
    ST_DATA   = 3'b010,
    ST_PARITY = 3'b011,
    ST_STOP   = 3'b100
  } state_t;

  localparam int DATA_WIDTH_MIN   = 5;
  localparam int DATA_WIDTH_MAX   = 9;
  localparam int CLKS_PER_BIT_MIN = 2;

  // Zero-extension to the widest legal word leaves the XOR reduction unchanged.
  function automatic logic frame_parity(input logic [DATA_WIDTH_MAX-1:0] data, input logic odd);
    return odd ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Word handshake, frame configuration and line/status outputs of the UART transmit engine.
// Handshake: a word is accepted on a rising edge where i_data_valid & o_ready; i_data and the
// config bits are sampled only on that edge, and i_data_valid while o_ready=0 has no effect.
interface uart_tx_serializer_if
  import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_data_valid;
    logic                  o_ready;
    logic                  i_par_en;
    logic                  i_par_odd;
    logic                  i_two_stop;
    logic                  o_serial_data;
    logic                  o_busy;
    logic                  o_done;
    state_t                dbg_state;

    modport master (
        output i_data, i_data_valid, i_par_en, i_par_odd, i_two_stop,
        input  o_ready, o_serial_data, o_busy, o_done, dbg_state
    );

    modport slave (
        input  i_data, i_data_valid, i_par_en, i_par_odd, i_two_stop,
        output o_ready, o_serial_data, o_busy, o_done, dbg_state
    );
endinterface

// File: rtl/uart_tx_bit_select.sv
// Maps the state a frame is about to be in, plus its data and parity bits, to the line level.
module uart_tx_bit_select
  import uart_pkg::*;
(
    input  state_t state,
    input  logic   data_bit,
    input  logic   parity_bit,
    output logic   line
);
    always_comb begin
        line = 1'b1;
        case (state)
            ST_START:  line = 1'b0;
            ST_DATA:   line = data_bit;
            ST_PARITY: line = parity_bit;
            default:   line = 1'b1;
        endcase
    end
endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit frame engine: start | data LSB-first | optional parity | 1-2 stop bits,
// with a registered idle-high line and zero-gap back-to-back frames.
module uart_tx_serializer
  import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input logic                  i_clk,
    input logic                  i_rst,
    uart_tx_serializer_if.slave  bus
);
    localparam int PW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX ||
        CLKS_PER_BIT < CLKS_PER_BIT_MIN) begin : g_bad_params
        $error("uart_tx_serializer: DATA_WIDTH or CLKS_PER_BIT out of range");
    end

    state_t                state, state_nxt;
    logic [PW-1:0]         prescaler;
    logic [BW-1:0]         bit_cnt;
    logic                  stop_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic                  par_en_q, two_stop_q, parity_q;
    logic                  serial_q;
    logic                  tick, last_bit, last_stop, done, ready, accept;
    logic                  data_bit_nxt, line_nxt;

    always_comb begin
        tick      = (prescaler == PRE_LAST);
        last_bit  = (bit_cnt == BIT_LAST);
        last_stop = (stop_cnt == two_stop_q);
        done      = (state == ST_STOP) && tick && last_stop;
        ready     = (state == ST_IDLE) || done;
        accept    = bus.i_data_valid && ready;

        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_START;
            ST_START:  if (tick) state_nxt = ST_DATA;
            ST_DATA:   if (tick && last_bit) state_nxt = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (tick) state_nxt = ST_STOP;
            ST_STOP:   if (done) state_nxt = accept ? ST_START : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase

        // The line is loaded with the level of the bit period that starts next cycle,
        // so on a data-bit boundary the bit after the current one is already at shift[1].
        data_bit_nxt = (state == ST_DATA && tick) ? shift[1] : shift[0];
    end

    uart_tx_bit_select u_bit_select (
        .state      (state_nxt),
        .data_bit   (data_bit_nxt),
        .parity_bit (parity_q),
        .line       (line_nxt)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            prescaler  <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            shift      <= '0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            parity_q   <= 1'b0;
            serial_q   <= 1'b1;
        end else begin
            state     <= state_nxt;
            serial_q  <= line_nxt;
            prescaler <= (state == ST_IDLE || tick) ? '0 : prescaler + PW'(1);

            if (state == ST_DATA) begin
                if (tick) bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
            end else begin
                bit_cnt <= '0;
            end

            if (state == ST_STOP) begin
                if (tick) stop_cnt <= ~last_stop;
            end else begin
                stop_cnt <= 1'b0;
            end

            if (accept) begin
                shift      <= bus.i_data;
                par_en_q   <= bus.i_par_en;
                two_stop_q <= bus.i_two_stop;
                parity_q   <= frame_parity(DATA_WIDTH_MAX'(bus.i_data), bus.i_par_odd);
            end else if (state == ST_DATA && tick) begin
                shift <= shift >> 1;
            end
        end
    end

    assign bus.o_serial_data = serial_q;
    assign bus.o_ready       = ready;
    assign bus.o_busy        = (state != ST_IDLE);
    assign bus.o_done        = done;
    assign bus.dbg_state     = state;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer at DATA_WIDTH=8, CLKS_PER_BIT=4: scenario tasks plus a line
// monitor that compares every bit period against the expected-bit queue.
module tb_uart_tx_serializer;
  import uart_pkg::*;

  localparam int DW  = 8;
  localparam int CPB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_serializer_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_serializer #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int chk_cnt = 0;
  int err_cnt = 0;

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];
  int         len_q[$];
  bit         mon_in_frame = 1'b0;
  int         mon_pos = 0;
  int         mon_nbits = 0;

  // Frame start = first low line sample while idle; each bit is sampled mid-period.
  always @(negedge clk) begin
    if (rst) begin
      mon_in_frame = 1'b0;
      exp_q.delete();
      len_q.delete();
    end else begin
      if (!mon_in_frame && bus.o_serial_data == 1'b0) begin
        chk_cnt++;
        if (len_q.size() == 0) begin
          err_cnt++;
          $display("FAIL unexpected_frame: start bit seen at %0t, required no frame", $time);
          mon_nbits = 10;
        end else begin
          mon_nbits = len_q.pop_front();
        end
        mon_in_frame = 1'b1;
        mon_pos = 0;
      end
      if (mon_in_frame) begin
        if (mon_pos % CPB == CPB / 2 && exp_q.size() > 0) begin
          logic [0:0] e;
          e = exp_q.pop_front();
          chk_cnt++;
          if (bus.o_serial_data !== e) begin
            err_cnt++;
            $display("FAIL line_bit: bit %0d at %0t got %b required %b",
                     mon_pos / CPB, $time, bus.o_serial_data, e);
          end
        end
        mon_pos++;
        if (mon_pos == mon_nbits * CPB) mon_in_frame = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_frame(input logic [DW-1:0] d, input logic pen, input logic podd,
                            input logic two);
    exp_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
    if (pen) exp_q.push_back(podd ? ~(^d) : ^d);
    exp_q.push_back(1'b1);
    if (two) exp_q.push_back(1'b1);
    len_q.push_back(1 + DW + int'(pen) + 1 + int'(two));
  endtask

  // Returns #1 after the accepting edge; the next negedge is cycle 1 of the frame.
  task automatic accept_word(input logic [DW-1:0] d, input logic pen, input logic podd,
                             input logic two, input bit keep_valid);
    int n;
    @(negedge clk);
    bus.i_data       = d;
    bus.i_par_en     = pen;
    bus.i_par_odd    = podd;
    bus.i_two_stop   = two;
    bus.i_data_valid = 1'b1;
    n = 0;
    while (bus.o_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_cnt++;
    if (n >= 200) begin
      err_cnt++;
      $display("FAIL accept_timeout: o_ready=%b after %0d cycles, required 1", bus.o_ready, n);
    end
    @(posedge clk);
    #1;
    if (!keep_valid) begin
      bus.i_data_valid = 1'b0;
      bus.i_data       = DW'($urandom_range(0, 255));
      bus.i_par_en     = 1'($urandom_range(0, 1));
      bus.i_par_odd    = 1'($urandom_range(0, 1));
      bus.i_two_stop   = 1'($urandom_range(0, 1));
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.i_data_valid = 1'b0;
    bus.i_data = '0;
    bus.i_par_en = 1'b0;
    bus.i_par_odd = 1'b0;
    bus.i_two_stop = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (bus.o_serial_data !== 1'b1 || bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0 ||
        bus.o_done !== 1'b0 || bus.dbg_state !== ST_IDLE) begin
      err_cnt++;
      $display("FAIL reset_state: line=%b ready=%b busy=%b done=%b state=%0d required 1 1 0 0 0",
               bus.o_serial_data, bus.o_ready, bus.o_busy, bus.o_done, bus.dbg_state);
    end
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (bus.o_serial_data !== 1'b1 || bus.o_busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL idle_after_reset: line=%b busy=%b required 1 0", bus.o_serial_data, bus.o_busy);
    end
  endtask

  task automatic test_single_even();
    int k;
    push_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    accept_word(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_cnt++;
    if (bus.o_busy !== 1'b1 || bus.o_ready !== 1'b0 || bus.o_serial_data !== 1'b0) begin
      err_cnt++;
      $display("FAIL first_cycle: busy=%b ready=%b line=%b required 1 0 0",
               bus.o_busy, bus.o_ready, bus.o_serial_data);
    end
    k = 1;
    while (bus.o_done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk_cnt++;
    if (k != 44) begin
      err_cnt++;
      $display("FAIL frame_len_even: o_done in cycle %0d, required 44", k);
    end
    @(negedge clk);
    chk_cnt++;
    if (bus.o_busy !== 1'b0 || bus.o_serial_data !== 1'b1) begin
      err_cnt++;
      $display("FAIL idle_after_frame: busy=%b line=%b required 0 1", bus.o_busy, bus.o_serial_data);
    end
  endtask

  task automatic test_parity_modes();
    logic [DW-1:0] pd[3] = '{8'hA5, 8'h00, 8'hFF};
    logic          po[3] = '{1'b1, 1'b0, 1'b1};
    logic          pe[3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      push_frame(pd[i], 1'b1, po[i], 1'b0);
      accept_word(pd[i], 1'b1, po[i], 1'b0, 1'b0);
      repeat (39) @(negedge clk);
      chk_cnt++;
      if (bus.o_serial_data !== pe[i]) begin
        err_cnt++;
        $display("FAIL parity_slot: data=%h odd=%b got %b required %b",
                 pd[i], po[i], bus.o_serial_data, pe[i]);
      end
      repeat (5) @(negedge clk);
      chk_cnt++;
      if (bus.o_done !== 1'b1) begin
        err_cnt++;
        $display("FAIL parity_frame_done: o_done=%b in cycle 44, required 1", bus.o_done);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_two_stop_no_parity();
    int k;
    push_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    accept_word(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.o_done !== 1'b1 && k < 100);
    chk_cnt++;
    if (k != 44) begin
      err_cnt++;
      $display("FAIL frame_len_two_stop: o_done in cycle %0d, required 44", k);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int rdy_bad = 0;
    int busy_low = 0;
    int n_done = 0;
    int d0 = 0;
    int d1 = 0;
    push_frame(8'h55, 1'b1, 1'b0, 1'b0);
    push_frame(8'hAA, 1'b1, 1'b1, 1'b1);
    accept_word(8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
    bus.i_data = 8'hAA;
    bus.i_par_odd = 1'b1;
    bus.i_two_stop = 1'b1;
    for (int k = 1; k <= 92; k++) begin
      @(negedge clk);
      if (bus.o_ready !== ((k == 44) || (k == 92))) rdy_bad++;
      if (bus.o_busy !== 1'b1) busy_low++;
      if (bus.o_done === 1'b1) begin
        if (n_done == 0) d0 = k;
        else d1 = k;
        n_done++;
      end
      if (k == 45) begin
        chk_cnt++;
        if (bus.o_serial_data !== 1'b0) begin
          err_cnt++;
          $display("FAIL b2b_start: line=%b in cycle 45, required 0", bus.o_serial_data);
        end
        bus.i_data_valid = 1'b0;
      end
    end
    chk_cnt++;
    if (rdy_bad != 0) begin
      err_cnt++;
      $display("FAIL b2b_ready: %0d cycles with wrong o_ready, required 0", rdy_bad);
    end
    chk_cnt++;
    if (busy_low != 0) begin
      err_cnt++;
      $display("FAIL b2b_gap: %0d idle cycles between frames, required 0", busy_low);
    end
    chk_cnt++;
    if (n_done != 2 || d0 != 44 || d1 != 92) begin
      err_cnt++;
      $display("FAIL b2b_done: %0d pulses at %0d,%0d required 2 at 44,92", n_done, d0, d1);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_ignore_busy();
    int k;
    int busy_after = 0;
    push_frame(8'h01, 1'b0, 1'b0, 1'b0);
    accept_word(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (11) @(negedge clk);
    bus.i_data = 8'hFF;
    bus.i_par_en = 1'b1;
    bus.i_two_stop = 1'b1;
    bus.i_data_valid = 1'b1;
    @(negedge clk);
    bus.i_data_valid = 1'b0;
    k = 12;
    while (bus.o_done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk_cnt++;
    if (k != 40) begin
      err_cnt++;
      $display("FAIL ignore_frame_len: o_done in cycle %0d, required 40", k);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.o_busy !== 1'b0 || bus.o_serial_data !== 1'b1) busy_after++;
    end
    chk_cnt++;
    if (busy_after != 0) begin
      err_cnt++;
      $display("FAIL ignore_no_second: %0d busy cycles after frame, required 0", busy_after);
    end
  endtask

  task automatic test_reset_mid_frame();
    int k;
    push_frame(8'h96, 1'b1, 1'b0, 1'b0);
    accept_word(8'h96, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (18) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_cnt++;
    if (bus.o_serial_data !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_ready !== 1'b1 ||
        bus.o_done !== 1'b0) begin
      err_cnt++;
      $display("FAIL async_reset: line=%b busy=%b ready=%b done=%b required 1 0 1 0",
               bus.o_serial_data, bus.o_busy, bus.o_ready, bus.o_done);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    push_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    accept_word(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.o_done !== 1'b1 && k < 100);
    chk_cnt++;
    if (k != 40) begin
      err_cnt++;
      $display("FAIL post_reset_frame: o_done in cycle %0d, required 40", k);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_drain();
    int n = 0;
    while ((len_q.size() != 0 || mon_in_frame) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk_cnt++;
    if (exp_q.size() != 0 || len_q.size() != 0) begin
      err_cnt++;
      $display("FAIL scoreboard_drain: %0d bits %0d frames left, required 0 0",
               exp_q.size(), len_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_even();
    test_parity_modes();
    test_two_stop_no_parity();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_frame();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end
endmodule
